// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// State encoding and counter sizing helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the step counter that runs from n-1 down to 0.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder with carry in and carry out.
// Pure combinational; the carry ripples LSB to MSB.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    input  logic         i_Cin,
    output logic [N-1:0] o_Sum,
    output logic         o_Cout
);

    logic c;

    always_comb begin
        o_Sum = '0;
        c     = i_Cin;
        for (int i = 0; i < N; i++) begin
            o_Sum[i] = i_A[i] ^ i_B[i] ^ c;
            c = (i_A[i] & i_B[i]) | (c & (i_A[i] ^ i_B[i]));
        end
        o_Cout = c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier, one partial-product add per clock.
// Valid/ready handshake on both operand input and product output.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    input  logic           i_Valid,
    output logic           o_Ready,
    input  logic [N-1:0]   i_A,
    input  logic [N-1:0]   i_B,
    output logic           o_Valid,
    input  logic           i_Ready,
    output logic [2*N-1:0] o_Product
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           carry;
    logic [2*N-1:0] shifted;
    logic           accept;

    assign addend = lo_q[0] ? m_q : '0;

    ripple_carry_adder #(.N(N)) u_rca (
        .i_A   (hi_q),
        .i_B   (addend),
        .i_Cin (1'b0),
        .o_Sum (sum),
        .o_Cout(carry)
    );

    // The (N+1)-bit sum lands on top; the consumed multiplier bit drops out.
    assign shifted = {carry, sum, lo_q[N-1:1]};

    assign o_Ready   = (state_q == IDLE) && i_Rst_n;
    assign o_Valid   = valid_q;
    assign o_Product = prod_q;
    assign accept    = i_Valid && o_Ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    m_d     = i_A;
                    hi_d    = '0;
                    lo_d    = i_B;
                    cnt_d   = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                {hi_d, lo_d} = shifted;
                if (cnt_q == '0) begin
                    prod_d  = shifted;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (i_Ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at N=4 and N=8.
// A latency/handshake model with plain A*B is compared every cycle.
module tb_shift_add_multiplier;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic       v4 = 0, r4 = 1, rdy4, ov4;
    logic [3:0] a4 = 0, b4 = 0;
    logic [7:0] p4;

    logic        v8 = 0, r8 = 1, rdy8, ov8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.N(4)) u4 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_Valid(v4), .o_Ready(rdy4),
        .i_A(a4), .i_B(b4),
        .o_Valid(ov4), .i_Ready(r4),
        .o_Product(p4)
    );

    shift_add_multiplier #(.N(8)) u8 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_Valid(v8), .o_Ready(rdy8),
        .i_A(a8), .i_B(b8),
        .o_Valid(ov8), .i_Ready(r8),
        .o_Product(p8)
    );

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: accepted operands produce A*B exactly N edges later,
    // held until i_Ready; product otherwise keeps its last value.
    bit            m_busy [2] = '{0, 0};
    bit            m_vld  [2] = '{0, 0};
    int            m_left [2] = '{0, 0};
    longint        m_exp  [2] = '{0, 0};
    longint        m_prod [2] = '{0, 0};

    task automatic model_step(input int d, input bit v, input bit r,
                              input longint a, input longint b,
                              input int n);
        if (m_vld[d]) begin
            if (r) m_vld[d] = 0;
        end else if (m_busy[d]) begin
            m_left[d]--;
            if (m_left[d] == 0) begin
                m_busy[d] = 0;
                m_vld[d]  = 1;
                m_prod[d] = m_exp[d];
            end
        end else if (v) begin
            m_busy[d] = 1;
            m_left[d] = n;
            m_exp[d]  = a * b;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0;
                m_vld[d]  = 0;
                m_prod[d] = 0;
            end
        end else begin
            model_step(0, v4, r4, longint'(a4), longint'(b4), 4);
            model_step(1, v8, r8, longint'(a8), longint'(b8), 8);
        end
    end

    always @(negedge clk) begin
        check("ready4", 64'(rdy4), 64'(!m_busy[0] && !m_vld[0] && rst_n));
        check("valid4", 64'(ov4), 64'(m_vld[0]));
        check("prod4", 64'(p4), 64'(m_prod[0]));
        check("ready8", 64'(rdy8), 64'(!m_busy[1] && !m_vld[1] && rst_n));
        check("valid8", 64'(ov8), 64'(m_vld[1]));
        check("prod8", 64'(p8), 64'(m_prod[1]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hands operands to the N=4 DUT and waits for o_Valid; checks latency.
    task automatic start4(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string nm);
        int lat;
        a4 = a;
        b4 = b;
        v4 = 1;
        lat = 0;
        while (!rdy4 && lat < 50) begin
            tick();
            lat++;
        end
        check({nm, "_acc"}, 64'(rdy4), 64'd1);
        tick();
        v4 = 0;
        a4 = ~a;
        b4 = ~b;
        check({nm, "_rdrop"}, 64'(rdy4), 64'd0);
        lat = 0;
        while (!ov4 && lat < 50) begin
            lat++;
            tick();
        end
        check({nm, "_lat"}, 64'(lat), 64'd4);
        check({nm, "_prod"}, 64'(p4), 64'(exp));
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input string nm);
        r4 = 1;
        start4(a, b, exp, nm);
        tick();
        check({nm, "_vdrop"}, 64'(ov4), 64'd0);
        check({nm, "_rback"}, 64'(rdy4), 64'd1);
    endtask

    initial begin
        int t, t1, t2, guard;
        #1 rst_n = 0;
        repeat (3) tick();
        check("rst_ready", 64'(rdy4), 64'd0);
        check("rst_prod", 64'(p4), 64'd0);
        rst_n = 1;
        #1 check("rel_ready", 64'(rdy4), 64'd1);
        tick();

        go4(4'd3, 4'd5, 8'd15, "t1");
        go4(4'd15, 4'd15, 8'd225, "t2");
        go4(4'd0, 4'd9, 8'd0, "t3a");
        go4(4'd9, 4'd0, 8'd0, "t3b");

        r4 = 0;
        start4(4'd7, 4'd6, 8'd42, "t4");
        a4 = 4'd1;
        b4 = 4'd1;
        v4 = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_v", 64'(ov4), 64'd1);
            check("t4_hold_p", 64'(p4), 64'd42);
            check("t4_hold_r", 64'(rdy4), 64'd0);
        end
        r4 = 1;
        v4 = 0;
        tick();
        check("t4_xfer", 64'(ov4), 64'd0);
        tick();
        check("t4_once", 64'(ov4), 64'd0);
        go4(4'd1, 4'd1, 8'd1, "t4b");

        a4 = 4'd12;
        b4 = 4'd11;
        v4 = 1;
        tick();
        v4 = 0;
        tick();
        rst_n = 0;
        #1;
        check("t5_valid", 64'(ov4), 64'd0);
        check("t5_prod", 64'(p4), 64'd0);
        check("t5_ready", 64'(rdy4), 64'd0);
        repeat (2) tick();
        rst_n = 1;
        tick();
        go4(4'd2, 4'd3, 8'd6, "t5b");

        r8 = 1;
        a8 = 8'd255;
        b8 = 8'd255;
        v8 = 1;
        tick();
        a8 = 8'd128;
        b8 = 8'd2;
        t = 0;
        while (!ov8 && t < 100) begin tick(); t++; end
        t1 = t;
        check("t6_p1", 64'(p8), 64'd65025);
        while (ov8 && t < 100) begin tick(); t++; end
        while (!ov8 && t < 100) begin tick(); t++; end
        t2 = t;
        v8 = 0;
        check("t6_p2", 64'(p8), 64'd256);
        check("t6_gap", 64'(t2 - t1), 64'd10);
        tick();

        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            v8 = 1;
            guard = 0;
            while (!rdy8 && guard < 100) begin
                r8 = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            check("sweep_to", 64'(guard < 100), 64'd1);
            tick();
            v8 = 0;
            r8 = 1'($urandom_range(0, 1));
        end
        r8 = 1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
